// File: rtl/turf_trigger_source_arbiter_pkg.sv
// turf_trig_pkg
//   Shared definitions for the TURF trigger source arbiter: the arbiter FSM
//   state encoding, conventional source indices and default widths.
//   Built without TRIG_SRC_SCALERS_EN by default. Defining it adds the
//   per-source scaler outputs to the top.
package turf_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_HOLD  = 2'd2
  } trig_state_e;

  localparam int SRC_SOFT = 0;
  localparam int SRC_EXT  = 1;
  localparam int SRC_PPS1 = 2;
  localparam int SRC_PPS2 = 3;

  localparam int DEF_N_SRC     = 4;
  localparam int DEF_PPS_SRC   = SRC_PPS1;
  localparam int DEF_DELAY_W   = 28;
  localparam int DEF_HOLDOFF_W = 16;
  localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/turf_trigger_source_arbiter_if.sv
// turf_trigger_source_arbiter_if
//   Trigger offer handshake between the arbiter and TRIGGER_INTERFACE.
//   trig_valid : trigger offered (master -> slave)
//   trig_mask  : sources contributing to the offered trigger (master -> slave)
//   trig_ready : downstream accepts the offer (slave -> master)
interface turf_trigger_source_arbiter_if #(
  parameter int N_SRC = 4
);
  logic             trig_valid;
  logic             trig_ready;
  logic [N_SRC-1:0] trig_mask;

  modport master (
    output trig_valid,
    output trig_mask,
    input  trig_ready
  );

  modport slave (
    input  trig_valid,
    input  trig_mask,
    output trig_ready
  );
endinterface

// File: rtl/turf_trigger_source_arbiter_pps_delay_timer.sv
// turf_pps_delay_timer
//   Detects a rise on the synchronous PPS level and, when armed, produces a
//   single-cycle pulse delay_i ticks later (delay 0: the cycle right after the
//   rise). A rise while the timer is running restarts it and flags restart_o.
//   Ports:
//     clk250_i, rst_n_i : clock, async active-low reset
//     pps_i             : PPS level
//     arm_en_i          : PPS source enabled; gates timer starts
//     clear_i           : stops the timer and blocks starts
//     delay_i           : delay in ticks, sampled when the timer starts
//     pps_rise_o        : raw PPS rise, independent of arm/clear
//     pulse_o           : delayed PPS trigger pulse
//     restart_o         : a qualified rise landed on a running timer
module turf_pps_delay_timer
  import turf_trig_pkg::*;
#(
  parameter int DELAY_W = DEF_DELAY_W
) (
  input  logic               clk250_i,
  input  logic               rst_n_i,
  input  logic               pps_i,
  input  logic               arm_en_i,
  input  logic               clear_i,
  input  logic [DELAY_W-1:0] delay_i,
  output logic               pps_rise_o,
  output logic               pulse_o,
  output logic               restart_o
);

  logic               pps_r;
  logic               running;
  logic [DELAY_W-1:0] remain;
  logic               start;

  // Down-counter loaded with the delay; terminal count 0 fires the pulse.
  assign pps_rise_o = pps_i & ~pps_r;
  assign start      = pps_rise_o & arm_en_i & ~clear_i;
  assign pulse_o    = running & (remain == '0);
  // A rise in the very cycle the pulse fires does not discard anything.
  assign restart_o  = start & running & ~pulse_o;

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pps_r   <= 1'b0;
      running <= 1'b0;
      remain  <= '0;
    end else begin
      pps_r <= pps_i;
      if (clear_i) begin
        running <= 1'b0;
        remain  <= '0;
      end else if (start) begin
        running <= 1'b1;
        remain  <= delay_i;
      end else if (pulse_o) begin
        running <= 1'b0;
      end else if (running) begin
        remain <= remain - DELAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/turf_trigger_source_arbiter.sv
// turf_trigger_source_arbiter
//   Edge-detects N_SRC trigger sources (source PPS_SRC replaced by a delayed
//   PPS pulse), applies per-source enables and a master disable, coalesces
//   simultaneous edges into one masked trigger and offers it downstream via a
//   valid/ready handshake followed by a programmable holdoff.
//   Optional TRIG_SRC_SCALERS_EN adds per-source edge scalers latched on PPS.
//   Ports:
//     clk250_i, rst_n_i : 250 MHz clock, async active-low reset
//     src_i, src_en_i   : source levels and per-source enables
//     disable_i         : master disable; clears pending and the PPS timer
//     pps_i             : PPS level
//     pps_delay_i       : PPS trigger delay in ticks
//     holdoff_i         : post-accept holdoff in ticks
//     trig_if           : trigger offer handshake (valid/mask out, ready in)
//     trig_count_o      : accepted triggers
//     lost_count_o      : coalesced/dropped edges and PPS restarts
//     scal_o, scal_stb_o: (TRIG_SRC_SCALERS_EN) latched scalers and strobe
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for any pending source; latches mask on the way out
//   ST_OFFER | trigger offered; valid/mask held until trig_ready
//   ST_HOLD  | post-accept holdoff; new edges keep accumulating in pending
module turf_trigger_source_arbiter
  import turf_trig_pkg::*;
#(
  parameter int N_SRC     = DEF_N_SRC,
  parameter int PPS_SRC   = DEF_PPS_SRC,
  parameter int DELAY_W   = DEF_DELAY_W,
  parameter int HOLDOFF_W = DEF_HOLDOFF_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                   clk250_i,
  input  logic                   rst_n_i,
  input  logic [N_SRC-1:0]       src_i,
  input  logic [N_SRC-1:0]       src_en_i,
  input  logic                   disable_i,
  input  logic                   pps_i,
  input  logic [DELAY_W-1:0]     pps_delay_i,
  input  logic [HOLDOFF_W-1:0]   holdoff_i,
  turf_trigger_source_arbiter_if.master trig_if,
  output logic [CNT_W-1:0]       trig_count_o,
  output logic [CNT_W-1:0]       lost_count_o
`ifdef TRIG_SRC_SCALERS_EN
  ,
  output logic [N_SRC*CNT_W-1:0] scal_o,
  output logic                   scal_stb_o
`endif
);

  trig_state_e          state;
  logic [HOLDOFF_W-1:0] hold_remain;
  logic [N_SRC-1:0]     src_r;
  logic [N_SRC-1:0]     src_rr;
  logic [N_SRC-1:0]     src_rise;
  logic [N_SRC-1:0]     rise_eff;
  logic [N_SRC-1:0]     set_vec;
  logic [N_SRC-1:0]     clear_vec;
  logic [N_SRC-1:0]     pending;
  logic                 take_pending;
  logic                 collide;
  logic                 pps_rise;
  logic                 pps_pulse;
  logic                 pps_restart;

  turf_pps_delay_timer #(
    .DELAY_W (DELAY_W)
  ) u_pps_timer (
    .clk250_i   (clk250_i),
    .rst_n_i    (rst_n_i),
    .pps_i      (pps_i),
    .arm_en_i   (src_en_i[PPS_SRC]),
    .clear_i    (disable_i),
    .delay_i    (pps_delay_i),
    .pps_rise_o (pps_rise),
    .pulse_o    (pps_pulse),
    .restart_o  (pps_restart)
  );

  assign src_rise = src_r & ~src_rr;

  always_comb begin
    rise_eff          = src_rise;
    rise_eff[PPS_SRC] = pps_pulse;
  end

  assign set_vec      = rise_eff & src_en_i & {N_SRC{~disable_i}};
  // Disable blocks the latch too, so a disabled cycle never opens a new offer.
  assign take_pending = (state == ST_IDLE) && (pending != '0) && !disable_i;
  assign clear_vec    = take_pending ? pending : '0;
  // Only an edge that really merges into an outstanding bit is lost; an edge
  // landing on a bit being latched this cycle survives as a fresh pending bit.
  assign collide      = |(set_vec & pending & ~clear_vec);

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_r        <= '0;
      src_rr       <= '0;
      pending      <= '0;
      lost_count_o <= '0;
    end else begin
      src_r        <= src_i;
      src_rr       <= src_r;
      pending      <= disable_i ? '0 : ((pending & ~clear_vec) | set_vec);
      lost_count_o <= lost_count_o + CNT_W'(collide) + CNT_W'(pps_restart);
    end
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state              <= ST_IDLE;
      trig_if.trig_valid <= 1'b0;
      trig_if.trig_mask  <= '0;
      trig_count_o       <= '0;
      hold_remain        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_pending) begin
            trig_if.trig_mask  <= pending;
            trig_if.trig_valid <= 1'b1;
            state              <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (trig_if.trig_ready) begin
            trig_if.trig_valid <= 1'b0;
            trig_if.trig_mask  <= '0;
            trig_count_o       <= trig_count_o + CNT_W'(1);
            if (holdoff_i != '0) begin
              // Loaded with holdoff-1 so HOLD lasts exactly holdoff_i cycles.
              hold_remain <= holdoff_i - HOLDOFF_W'(1);
              state       <= ST_HOLD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (hold_remain == '0) begin
            state <= ST_IDLE;
          end else begin
            hold_remain <= hold_remain - HOLDOFF_W'(1);
          end
        end
        default: begin
          state              <= ST_IDLE;
          trig_if.trig_valid <= 1'b0;
          trig_if.trig_mask  <= '0;
        end
      endcase
    end
  end

`ifdef TRIG_SRC_SCALERS_EN
  logic [CNT_W-1:0] scal_cnt [N_SRC];
  logic             scal_latched;

  // On a PPS rise the running counts are published and restarted; an edge in
  // that same cycle becomes the first count of the new second.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N_SRC; i++) begin
        scal_cnt[i] <= '0;
      end
      scal_o       <= '0;
      scal_latched <= 1'b0;
      scal_stb_o   <= 1'b0;
    end else begin
      scal_latched <= pps_rise;
      scal_stb_o   <= scal_latched;
      for (int i = 0; i < N_SRC; i++) begin
        if (pps_rise) begin
          scal_o[i*CNT_W +: CNT_W] <= scal_cnt[i];
          scal_cnt[i]              <= CNT_W'(set_vec[i]);
        end else begin
          scal_cnt[i] <= scal_cnt[i] + CNT_W'(set_vec[i]);
        end
      end
    end
  end
`endif

endmodule
